// File: rtl/lsu_memctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Unsupported encodings and misaligned halves/words both count as illegal.
    function automatic logic lsu_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (we) begin
            if (funct3 != F3_SB && funct3 != F3_SH && funct3 != F3_SW)
                bad = 1'b1;
        end else if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
            bad = 1'b1;
        end
        if (funct3[1:0] == 2'b01 && lane[0])
            bad = 1'b1;
        if (funct3[1:0] == 2'b10 && lane != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_memctrl_if.sv
// Request/response and datamemory bus of the load/store unit.
// master = datapath plus memory side, slave = the LSU itself.
interface lsu_memctrl_if #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [2:0]              req_funct3;
    logic [P_ADDR_WIDTH+1:0] req_addr;
    logic [P_DATA_WIDTH-1:0] req_wdata;
    logic                    rsp_valid;
    logic [P_DATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_err;
    logic                    mem_we;
    logic [P_ADDR_WIDTH-1:0] mem_addr;
    logic [P_DATA_WIDTH-1:0] mem_wdata;
    logic [P_DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_memctrl_align.sv
// Combinational lane logic: little-endian load extract/extend and
// sub-word store merge into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [4:0]  bit_off;
    logic [31:0] shifted;

    assign bit_off = {lane, 3'b000};
    assign shifted = word >> bit_off;

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'b0, shifted[7:0]};
            F3_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        merge_data = wdata;
        case (funct3)
            F3_SB:   merge_data = (word & ~(32'h0000_00FF << bit_off))
                                | ({24'b0, wdata[7:0]} << bit_off);
            F3_SH:   merge_data = (word & ~(32'h0000_FFFF << bit_off))
                                | ({16'b0, wdata[15:0]} << bit_off);
            default: merge_data = wdata;
        endcase
    end
endmodule

// File: rtl/lsu_memctrl.sv
// Load/store initiator between the datapath and a word-only, async-read
// datamemory; sub-word stores are done as read-modify-write.
module lsu_memctrl
    import lsu_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    lsu_memctrl_if.slave bus
);
    localparam int AW = P_ADDR_WIDTH;

    if (P_DATA_WIDTH != 32) begin : g_bad_width
        $error("lsu_memctrl supports only P_DATA_WIDTH = 32");
    end

    lsu_state_t  state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_align u_align (
        .funct3     (r_funct3),
        .lane       (r_lane),
        .word       (bus.mem_rdata),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_wdata     <= 32'b0;
            r_merge     <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_funct3   <= bus.req_funct3;
                        r_lane     <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        mem_addr_q <= bus.req_addr[AW+1:2];
                        if (lsu_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            rsp_rdata_q <= 32'b0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        rsp_rdata_q <= load_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else if (r_funct3 == F3_SW) begin
                        rsp_rdata_q <= 32'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        r_merge <= merge_data;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    rsp_rdata_q <= 32'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so an async reset drops the write at once.
    assign bus.mem_we    = (state == ST_WRITE) ||
                           (state == ST_ACCESS && r_we && r_funct3 == F3_SW);
    assign bus.mem_wdata = (state == ST_WRITE) ? r_merge : r_wdata;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_memctrl.sv
// Self-checking bench for lsu_memctrl: vector table with a response
// scoreboard, plus hand-written reset sequences.
module tb_lsu_memctrl;
    import lsu_pkg::*;

    localparam int AW = 8;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [3:0]  pulses;
        logic [63:0] tag;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [3:0]  pulses;
        logic [7:0]  maddr;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   numChecks = 0;
    int   numPassed = 0;
    exp_t sbq[$];
    vec_t vecs[25];
    logic [31:0] mem [0:255];

    lsu_memctrl_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(32)) bus();

    lsu_memctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Word memory with combinational read, write on the clock edge.
    always @(posedge i_clk) begin
        if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    function automatic vec_t mkVec(input logic we, input logic [2:0] f3,
                                   input logic [9:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input logic err,
                                   input logic [3:0] lat, input logic [3:0] pulses,
                                   input logic [63:0] tag);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.pulses = pulses; v.tag = tag;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        numChecks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else
            numPassed++;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        exp_t got_e;
        int   cycles;
        int   pulses;
        logic got;
        logic busyOk;
        e.rdata  = v.rdata;
        e.err    = v.err;
        e.lat    = v.lat;
        e.pulses = v.pulses;
        e.maddr  = v.addr[9:2];
        sbq.push_back(e);
        @(negedge i_clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge i_clk);
        #1 bus.req_valid = 1'b0;
        cycles = 0; pulses = 0; got = 1'b0; busyOk = 1'b1;
        while (!got && cycles < 8) begin
            @(negedge i_clk);
            cycles++;
            if (bus.mem_we) pulses++;
            if (bus.req_ready) busyOk = 1'b0;
            if (bus.rsp_valid) got = 1'b1;
        end
        got_e = sbq.pop_front();
        checkOutput($sformatf("%s_seen", v.tag), {31'b0, got}, 32'd1);
        checkOutput($sformatf("%s_rdata", v.tag), bus.rsp_rdata, got_e.rdata);
        checkOutput($sformatf("%s_err", v.tag), {31'b0, bus.rsp_err}, {31'b0, got_e.err});
        checkOutput($sformatf("%s_lat", v.tag), cycles, {28'b0, got_e.lat});
        checkOutput($sformatf("%s_wepulses", v.tag), pulses, {28'b0, got_e.pulses});
        checkOutput($sformatf("%s_maddr", v.tag), {24'b0, bus.mem_addr}, {24'b0, got_e.maddr});
        checkOutput($sformatf("%s_busy", v.tag), {31'b0, busyOk}, 32'd1);
        @(negedge i_clk);
        checkOutput($sformatf("%s_pulse1", v.tag), {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput($sformatf("%s_idle", v.tag), {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        logic sawRsp;
        vecs[0]  = mkVec(1, F3_SW,  10'h010, 32'hDEADBEEF, 32'h00000000, 0, 2, 1, "sw_10");
        vecs[1]  = mkVec(1, F3_SB,  10'h011, 32'h000000AA, 32'h00000000, 0, 3, 1, "sb_11");
        vecs[2]  = mkVec(0, F3_LB,  10'h013, 32'h0,        32'hFFFFFFDE, 0, 2, 0, "lb_13");
        vecs[3]  = mkVec(0, F3_LBU, 10'h013, 32'h0,        32'h000000DE, 0, 2, 0, "lbu_13");
        vecs[4]  = mkVec(0, F3_LH,  10'h012, 32'h0,        32'hFFFFDEAD, 0, 2, 0, "lh_12");
        vecs[5]  = mkVec(0, F3_LHU, 10'h012, 32'h0,        32'h0000DEAD, 0, 2, 0, "lhu_12");
        vecs[6]  = mkVec(0, F3_LW,  10'h010, 32'h0,        32'hDEADAAEF, 0, 2, 0, "lw_10");
        vecs[7]  = mkVec(0, F3_LW,  10'h012, 32'h0,        32'h00000000, 1, 1, 0, "lw_mis");
        vecs[8]  = mkVec(1, F3_SH,  10'h011, 32'h12345678, 32'h00000000, 1, 1, 0, "sh_mis");
        vecs[9]  = mkVec(0, 3'b011, 10'h010, 32'h0,        32'h00000000, 1, 1, 0, "ld_f011");
        vecs[10] = mkVec(1, F3_SH,  10'h012, 32'hFFFF1234, 32'h00000000, 0, 3, 1, "sh_12");
        vecs[11] = mkVec(0, F3_LH,  10'h012, 32'h0,        32'h00001234, 0, 2, 0, "lh_pos");
        vecs[12] = mkVec(0, F3_LB,  10'h010, 32'h0,        32'hFFFFFFEF, 0, 2, 0, "lb_10");
        vecs[13] = mkVec(0, F3_LHU, 10'h010, 32'h0,        32'h0000AAEF, 0, 2, 0, "lhu_10");
        vecs[14] = mkVec(1, 3'b011, 10'h010, 32'h11111111, 32'h00000000, 1, 1, 0, "st_f011");
        vecs[15] = mkVec(0, F3_LB,  10'h011, 32'h0,        32'hFFFFFFAA, 0, 2, 0, "lb_11");
        vecs[16] = mkVec(1, F3_SW,  10'h020, 32'h80000001, 32'h00000000, 0, 2, 1, "sw_20");
        vecs[17] = mkVec(0, F3_LB,  10'h023, 32'h0,        32'hFFFFFF80, 0, 2, 0, "lb_23");
        vecs[18] = mkVec(0, F3_LH,  10'h020, 32'h0,        32'h00000001, 0, 2, 0, "lh_20");
        vecs[19] = mkVec(0, 3'b110, 10'h020, 32'h0,        32'h00000000, 1, 1, 0, "ld_f110");
        vecs[20] = mkVec(1, 3'b100, 10'h020, 32'h22222222, 32'h00000000, 1, 1, 0, "st_f100");
        vecs[21] = mkVec(1, F3_SB,  10'h023, 32'hFFFFFF7F, 32'h00000000, 0, 3, 1, "sb_23");
        vecs[22] = mkVec(0, F3_LB,  10'h023, 32'h0,        32'h0000007F, 0, 2, 0, "lb_23b");
        vecs[23] = mkVec(1, F3_SW,  10'h3FC, 32'hA5A55A5A, 32'h00000000, 0, 2, 1, "sw_top");
        vecs[24] = mkVec(0, F3_LW,  10'h3FC, 32'h0,        32'hA5A55A5A, 0, 2, 0, "lw_top");

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        #12;
        checkOutput("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rst_rspvalid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("rst_memwe", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("rst_memaddr", {24'b0, bus.mem_addr}, 32'd0);
        checkOutput("rst_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 25; i++)
            applyStimulus(vecs[i]);

        checkOutput("mem4_final", mem[4], 32'h1234AAEF);
        checkOutput("mem8_final", mem[8], 32'h7F000001);
        checkOutput("mem255_final", mem[255], 32'hA5A55A5A);

        // SB to word 4, reset lands in the WRITE cycle before its write edge.
        @(negedge i_clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_SB;
        bus.req_addr   = 10'h011;
        bus.req_wdata  = 32'h00000055;
        @(posedge i_clk);
        #1 bus.req_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("rmw_read_we", {31'b0, bus.mem_we}, 32'd0);
        @(negedge i_clk);
        checkOutput("rmw_write_we", {31'b0, bus.mem_we}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        checkOutput("midrst_memwe", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("midrst_memaddr", {24'b0, bus.mem_addr}, 32'd0);
        checkOutput("midrst_rspvalid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst  = 1'b0;
        sawRsp = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            if (bus.rsp_valid) sawRsp = 1'b1;
        end
        checkOutput("midrst_no_rsp", {31'b0, sawRsp}, 32'd0);
        checkOutput("midrst_mem4", mem[4], 32'h1234AAEF);
        checkOutput("midrst_ready2", {31'b0, bus.req_ready}, 32'd1);

        applyStimulus(mkVec(0, F3_LW, 10'h010, 32'h0, 32'h1234AAEF, 0, 2, 0, "lw_after"));

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end
endmodule
